// File: rtl/bcd_code_converter_seq.sv
// Sequential BCD code converter: latches a packed BCD word and emits one converted
// digit per clock (LSD first) in 8421, excess-3, 2421 or Gray, flagging digits > 9.
module bcd_code_converter_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   code_out,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        bcd_q, bcd_d;
    logic [1:0]          mode_q, mode_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [W-1:0]        code_q, code_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [3:0]          conv_arr [DIGITS];
    logic [DIGITS-1:0]   bad_arr;

    function automatic logic [3:0] conv_digit(input logic [3:0] v, input logic [1:0] m);
        logic [3:0] r;
        r = 4'd0;
        if (v <= 4'd9) begin
            case (m)
                2'b00:   r = v;
                2'b01:   r = v + 4'd3;
                2'b10:   r = (v < 4'd5) ? v : v + 4'd6;
                default: r = v ^ (v >> 1);
            endcase
        end
        return r;
    endfunction

    // Every digit is converted in parallel; the FSM only chooses which one to commit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign conv_arr[gi] = conv_digit(bcd_q[4*gi +: 4], mode_q);
        assign bad_arr[gi]  = (bcd_q[4*gi +: 4] > 4'd9);
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        code_d  = code_q;
        mask_d  = mask_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bcd_d   = bcd_in;
                    mode_d  = mode;
                    code_d  = '0;
                    mask_d  = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        code_d[4*i +: 4] = conv_arr[i];
                        mask_d[i]        = bad_arr[i];
                    end
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // err tracks the mask it will sit beside after this edge.
        err_d = |mask_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            mode_q  <= 2'b00;
            idx_q   <= '0;
            code_q  <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign code_out = code_q;
    assign err_mask = mask_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_code_converter_seq.sv
// Bench for bcd_code_converter_seq: directed vectors plus random conversions checked
// against a digit-by-digit arithmetic reference model.
module tb_bcd_code_converter_seq;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [W-1:0]      bcd_in = '0;
    logic              busy, done, err;
    logic [W-1:0]      code_out;
    logic [DIGITS-1:0] err_mask;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_code_converter_seq #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bcd_in(bcd_in),
        .busy(busy), .done(done), .code_out(code_out), .err_mask(err_mask), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: each digit taken with plain arithmetic, mapped by table/arithmetic rules.
    task automatic model(input int m, input int word, output int code, output int mask);
        int tbl2421 [10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
        int v, o;
        code = 0;
        mask = 0;
        for (int i = 0; i < DIGITS; i++) begin
            v = (word / (1 << (4 * i))) % 16;
            if (v > 9) begin
                o = 0;
                mask += (1 << i);
            end else if (m == 0) o = v;
            else if (m == 1) o = v + 3;
            else if (m == 2) o = tbl2421[v];
            else o = v ^ (v / 2);
            code += o * (1 << (4 * i));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_code"}, 32'(code_out), 32'd0);
        chk({tag, "_mask"}, 32'(err_mask), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Starts a conversion at a negedge and follows it cycle by cycle to completion.
    // With perturb set, start is pulsed and operands are scrambled mid-conversion.
    task automatic run_conv(input logic [1:0] m, input logic [W-1:0] b, input bit perturb);
        int ecode, emask;
        model(int'(m), int'(b), ecode, emask);
        mode = m;
        bcd_in = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < DIGITS; c++) begin
            chk("conv_busy", 32'(busy), 32'd1);
            chk("conv_done", 32'(done), 32'd0);
            if (perturb && c == 1) begin
                start = 1'b1;
                mode = 2'($urandom_range(0, 3));
                bcd_in = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_code", 32'(code_out), 32'(ecode));
        chk("fin_mask", 32'(err_mask), 32'(emask));
        chk("fin_err", 32'(err), 32'(emask != 0));
        $display("conv mode=%0d in=%h out=%h mask=%b err=%0d", m, b, code_out, err_mask, err);
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("hold_code", 32'(code_out), 32'(ecode));
        chk("hold_mask", 32'(err_mask), 32'(emask));
    endtask

    initial begin
        int gap, waited;
        logic [W-1:0] rb;

        #1;
        check_zero("rst_init");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        run_conv(2'b01, 16'h1947, 1'b0);
        chk("x3_1947", 32'(code_out), 32'h4C7A);
        run_conv(2'b10, 16'h5609, 1'b0);
        chk("2421_5609", 32'(code_out), 32'hBC0F);
        run_conv(2'b11, 16'h0789, 1'b0);
        chk("gray_0789", 32'(code_out), 32'h04CD);
        run_conv(2'b01, 16'h1A3F, 1'b0);
        chk("x3_1A3F_mask", 32'(err_mask), 32'b0101);
        run_conv(2'b10, 16'h9876, 1'b1);

        // Asynchronous reset in the middle of a conversion and mid-cycle.
        mode = 2'b01; bcd_in = 16'h9999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        run_conv(2'b00, 16'h2580, 1'b0);
        chk("pass_2580", 32'(code_out), 32'h2580);

        // Start held high: conversions repeat every DIGITS+2 cycles.
        mode = 2'b11; bcd_in = 16'h1234; start = 1'b1;
        waited = 0;
        while (!done && waited < 20) begin @(negedge clk); waited++; end
        chk("hold_first_done", 32'(done), 32'd1);
        @(negedge clk);
        gap = 1;
        while (!done && gap < 20) begin @(negedge clk); gap++; end
        chk("b2b_period", 32'(gap), 32'(DIGITS + 2));
        start = 1'b0;
        repeat (DIGITS + 3) @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd0);

        for (int t = 0; t < 40; t++) begin
            rb = W'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                for (int i = 0; i < DIGITS; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            run_conv(2'($urandom_range(0, 3)), rb, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bcd_code_converter_seq.md
Name: bcd_code_converter_seq

Overview:
Sequential, parametrised successor to the combinational 4-bit BCD code converter. It accepts a DIGITS-wide packed BCD word and converts it one digit per clock, least significant digit first. The target code is selected at run time: 8421 pass-through, excess-3, 2421 or Gray. A start/busy/done handshake and per-digit invalid-digit flags feed the display and datapath labs downstream.

Parameters:
DIGITS, 4, number of packed BCD digits (>=1); data width is 4*DIGITS

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
mode  input  2  code select: 00=8421 pass, 01=excess-3, 10=2421, 11=Gray
bcd_in  input  4*DIGITS  packed BCD word, digit i = bits [4i+3:4i]
busy  output  1  high while a conversion is in progress (CONV state)
done  output  1  one-cycle pulse when code_out/err are complete
code_out  output  4*DIGITS  converted word, digit i at [4i+3:4i]
err_mask  output  DIGITS  bit i set if input digit i was >9
err  output  1  OR of err_mask

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high. All flops reset immediately on rst=1: state=IDLE, busy=0, done=0, code_out=0, err_mask=0, err=0, digit index=0.
- FSM states: IDLE, CONV, DONE.
- IDLE, start=1 at edge k:
  - Latch bcd_in and mode into internal registers.
  - Clear code_out and err_mask.
  - idx=0, go to CONV; busy=1 from edge k.
  - Inputs are not resampled after this edge.
- CONV: at each edge, write converted digit idx into code_out[4idx+3:4idx] and set err_mask[idx] if needed, then idx++.
  - The edge that writes digit DIGITS-1 moves to DONE: busy=0, done=1.
  - Digits are written at edges k+1..k+DIGITS.
  - done is high for the single cycle after edge k+DIGITS.
- DONE: next edge returns to IDLE with done=0.
- Output hold: code_out, err_mask and err hold their values until the next accepted start.
- start handling: start is ignored in CONV and DONE, with no queuing. A start held high in IDLE after DONE begins a new conversion. Back-to-back period is DIGITS+2 cycles.
- Per-digit mapping, value v in 0..9:
  - 8421: v.
  - excess-3: v+3, 4-bit.
  - 2421: v for 0..4; v+6 for 5..9 (5=1011 ... 9=1111).
  - Gray: v ^ (v>>1).
- Invalid digit (v>9): output digit 4'b0000 in every mode, err_mask bit set.
- err: registered; equals |err_mask at all times, valid at done.
- rst mid-conversion: aborts immediately and all outputs return to their reset values. The first start after rst deasserts is accepted normally.
- DIGITS=1: busy lasts 1 cycle, done follows at the next cycle.

Test Plan:
- rst pulse (asynchronous, mid-cycle) -> all outputs 0 immediately, state IDLE.
- DIGITS=4, mode=01, bcd_in=16'h1947, start 1 cycle -> busy high 4 cycles, then done 1 cycle, code_out=16'h4C7A, err=0.
- mode=10, bcd_in=16'h5609 -> code_out=16'hBC0F, err_mask=4'b0000; mode=11, bcd_in=16'h0789 -> code_out=16'h04CD.
- mode=01, bcd_in=16'h1A3F -> code_out=16'h4060, err_mask=4'b0101, err=1 at done.
- start pulsed during CONV, with bcd_in/mode changed mid-conversion -> ignored; result matches the originally latched operands; exactly one done.
- rst asserted 2 cycles into a conversion, then new start with mode=00, bcd_in=16'h2580 -> clean restart, code_out=16'h2580 at done.
